lbist_ctrl: RTL and testbench



---
 rtl/lbist_ctrl.sv | 90 +++++++++
 tb/tb_lbist_ctrl.sv | 165 ++++++++++++++++
 2 files changed

// File: rtl/lbist_ctrl.sv
// lbist_ctrl: logic-BIST sequencer for TPG, MISR and core scan control; `define LBIST_ABORT_EN adds the lbist_abort input.
module lbist_ctrl #(
  parameter int N_PATTERNS = 1024,
  parameter int CHAIN_LEN = 200,
  parameter int SIG_W = 32,
  parameter logic [SIG_W-1:0] GOLDEN_SIG = '0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic lbist_start,
`ifdef LBIST_ABORT_EN
  input  logic lbist_abort,
`endif
  input  logic [SIG_W-1:0] misr_sig,
  output logic tpg_en,
  output logic tpg_rst_n,
  output logic misr_en,
  output logic scan_en,
  output logic test_mode,
  output logic lbist_done,
  output logic lbist_pass
);
  localparam int SW = $clog2(CHAIN_LEN + 1);
  localparam int PW = $clog2(N_PATTERNS + 1);
  localparam logic [SW-1:0] SHIFT_LAST = SW'(CHAIN_LEN - 1);
  localparam logic [PW-1:0] PAT_LAST = PW'(N_PATTERNS);
  typedef enum logic [2:0] {IDLE, INIT, SHIFT, CAPTURE, UNLOAD, COMPARE, DONE} state_t;
  state_t state_q, state_d;
  logic [SW-1:0] shift_cnt, shift_d;
  logic [PW-1:0] pat_cnt, pat_d;
  logic abort_hit, last, pass_d;
  assign last = shift_cnt == SHIFT_LAST;
  always_comb begin
    state_d = state_q;
    shift_d = shift_cnt;
    pat_d = pat_cnt;
    abort_hit = 1'b0;
    case (state_q)
      IDLE: state_d = lbist_start ? INIT : IDLE;
      INIT: begin
        shift_d = '0;
        pat_d = '0;
        state_d = SHIFT;
      end
      SHIFT, UNLOAD: begin
        shift_d = last ? '0 : shift_cnt + 1'b1;
        state_d = !last ? state_q : (state_q == SHIFT) ? CAPTURE : COMPARE;
      end
      CAPTURE: begin
        pat_d = pat_cnt + 1'b1;
        state_d = (pat_d == PAT_LAST) ? UNLOAD : SHIFT;
      end
      COMPARE: state_d = DONE;
      DONE: state_d = lbist_start ? DONE : IDLE;
      default: state_d = IDLE;
    endcase
`ifdef LBIST_ABORT_EN
    abort_hit = lbist_abort && state_q != IDLE && state_q != DONE;
    if (abort_hit) state_d = DONE;
`endif
  end
  // pass is captured on the COMPARE->DONE edge and held for as long as DONE lasts
  assign pass_d = state_d == DONE && !abort_hit &&
                  ((state_q == COMPARE) ? (misr_sig == GOLDEN_SIG) : (state_q == DONE) && lbist_pass);
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      shift_cnt <= '0;
      pat_cnt <= '0;
      tpg_en <= 1'b0;
      tpg_rst_n <= 1'b1;
      misr_en <= 1'b0;
      scan_en <= 1'b0;
      test_mode <= 1'b0;
      lbist_done <= 1'b0;
      lbist_pass <= 1'b0;
    end else begin
      state_q <= state_d;
      shift_cnt <= shift_d;
      pat_cnt <= pat_d;
      tpg_en <= state_d == SHIFT;
      tpg_rst_n <= state_d != INIT;
      misr_en <= (state_d == SHIFT && pat_d != '0) || state_d == CAPTURE || state_d == UNLOAD;
      scan_en <= state_d == SHIFT || state_d == UNLOAD;
      test_mode <= state_d inside {INIT, SHIFT, CAPTURE, UNLOAD, COMPARE};
      lbist_done <= state_d == DONE;
      lbist_pass <= pass_d;
    end
  end
endmodule

// File: tb/tb_lbist_ctrl.sv
// tb_lbist_ctrl: directed bench for lbist_ctrl with N_PATTERNS=3, CHAIN_LEN=4.
module tb_lbist_ctrl;
  localparam logic [31:0] GOLD = 32'hA5A5_1234;
  localparam logic [6:0] RST_V = 7'b0100000;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic lbist_start = 1'b0;
  logic [31:0] misr_sig = '0;
  logic tpg_en, tpg_rst_n, misr_en, scan_en, test_mode, lbist_done, lbist_pass;
  logic [6:0] obs;
  int total = 0;
  int bad = 0;
`ifdef LBIST_ABORT_EN
  logic lbist_abort = 1'b0;
`endif
  lbist_ctrl #(.N_PATTERNS(3), .CHAIN_LEN(4), .SIG_W(32), .GOLDEN_SIG(GOLD)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .lbist_start(lbist_start),
`ifdef LBIST_ABORT_EN
    .lbist_abort(lbist_abort),
`endif
    .misr_sig(misr_sig),
    .tpg_en(tpg_en),
    .tpg_rst_n(tpg_rst_n),
    .misr_en(misr_en),
    .scan_en(scan_en),
    .test_mode(test_mode),
    .lbist_done(lbist_done),
    .lbist_pass(lbist_pass)
  );
  always #5 clk = ~clk;
  assign obs = {tpg_en, tpg_rst_n, misr_en, scan_en, test_mode, lbist_done, lbist_pass};
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  // Expected output vector k cycles after the start-sampling edge
  function automatic logic [6:0] expect_at(input int k, input logic pass);
    int p;
    logic sh, cap, unl;
    if (k == 0) return 7'b0000100;
    if (k >= 21) return {5'b01000, 1'b1, pass};
    p = k - 1;
    sh = p < 15 && (p % 5) < 4;
    cap = p < 15 && (p % 5) == 4;
    unl = p >= 15 && p < 19;
    return {sh, 1'b1, (sh && p / 5 > 0) || cap || unl, sh || unl, 1'b1, 2'b00};
  endfunction
  task automatic test_reset;
    #12;
    total++;
    if (obs !== RST_V) begin
      bad++;
      $display("FAIL reset_hold got=%b exp=%b", obs, RST_V);
    end
    rst_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      total++;
      if (obs !== RST_V) begin
        bad++;
        $display("FAIL reset_idle cyc=%0d got=%b exp=%b", i, obs, RST_V);
      end
    end
  endtask
  task automatic test_full_run(input logic [31:0] sig, input logic pass, input logic drop);
    logic [6:0] e;
    misr_sig = sig;
    lbist_start = 1'b1;
    for (int k = 0; k <= 21; k++) begin
      tick();
      if (drop) lbist_start = 1'b0;
      e = expect_at(k, pass);
      total++;
      if (obs !== e) begin
        bad++;
        $display("FAIL run_seq drop=%0d k=%0d got=%b exp=%b", drop, k, obs, e);
      end
    end
    if (!drop) begin
      for (int i = 0; i < 3; i++) begin
        tick();
        e = expect_at(21, pass);
        total++;
        if (obs !== e) begin
          bad++;
          $display("FAIL done_hold cyc=%0d got=%b exp=%b", i, obs, e);
        end
      end
      lbist_start = 1'b0;
    end
    tick();
    total++;
    if (obs !== RST_V) begin
      bad++;
      $display("FAIL done_to_idle got=%b exp=%b", obs, RST_V);
    end
  endtask
  task automatic test_midrun_reset;
    misr_sig = GOLD;
    lbist_start = 1'b1;
    repeat (8) tick();
    total++;
    if (obs !== expect_at(7, 1'b0)) begin
      bad++;
      $display("FAIL second_shift got=%b exp=%b", obs, expect_at(7, 1'b0));
    end
    #2 rst_n = 1'b0;
    #1;
    total++;
    if (obs !== RST_V) begin
      bad++;
      $display("FAIL async_reset got=%b exp=%b", obs, RST_V);
    end
    lbist_start = 1'b0;
    #3 rst_n = 1'b1;
    repeat (3) tick();
    total++;
    if (obs !== RST_V) begin
      bad++;
      $display("FAIL post_reset_idle got=%b exp=%b", obs, RST_V);
    end
    test_full_run(GOLD, 1'b1, 1'b0);
  endtask
`ifdef LBIST_ABORT_EN
  task automatic test_abort;
    misr_sig = GOLD;
    lbist_start = 1'b1;
    repeat (11) tick();
    total++;
    if (obs !== expect_at(10, 1'b0)) begin
      bad++;
      $display("FAIL second_capture got=%b exp=%b", obs, expect_at(10, 1'b0));
    end
    lbist_abort = 1'b1;
    tick();
    lbist_abort = 1'b0;
    total++;
    if (obs !== 7'b0100010) begin
      bad++;
      $display("FAIL abort_done got=%b exp=%b", obs, 7'b0100010);
    end
    lbist_start = 1'b0;
    tick();
    total++;
    if (obs !== RST_V) begin
      bad++;
      $display("FAIL abort_idle got=%b exp=%b", obs, RST_V);
    end
  endtask
`endif
  initial begin
    test_reset();
    test_full_run(GOLD, 1'b1, 1'b0);
    test_full_run(GOLD ^ 32'h1, 1'b0, 1'b0);
    test_full_run(GOLD, 1'b1, 1'b1);
    test_midrun_reset();
`ifdef LBIST_ABORT_EN
    test_abort();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
